// File: rtl/trap_sequencer.sv
// Trap entry / xRET sequencer: drains the pipeline, writes xEPC/xCAUSE/xTVAL/mstatus
// through the shared CSR write port, updates privilege and redirects fetch.
module trap_sequencer #(
  parameter int XLEN            = 32,
  parameter bit VECTORED_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trapValid,
  input  logic            trapIsInterrupt,
  input  logic [4:0]      trapCause,
  input  logic [XLEN-1:0] trapValue,
  input  logic [XLEN-1:0] trapPc,
  input  logic            retValid,
  input  logic [1:0]      retPrivilege,
  output logic            reqReady,
  input  logic            pipelineEmpty,
  output logic            flush,
  input  logic [1:0]      privilege,
  output logic            privWriteEnable,
  output logic [1:0]      privWriteValue,
  input  logic [XLEN-1:0] medeleg,
  input  logic [XLEN-1:0] mideleg,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] sepc,
  input  logic [XLEN-1:0] mstatus,
  input  logic            pipeWriteEnable,
  input  logic [11:0]     pipeWriteAddr,
  input  logic [XLEN-1:0] pipeWriteValue,
  output logic            csrWriteEnable,
  output logic [11:0]     csrWriteAddr,
  output logic [XLEN-1:0] csrWriteValue,
  output logic            redirectValid,
  output logic [XLEN-1:0] redirectPc,
  output logic [2:0]      dbgState
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_WR_EPC, S_WR_CAUSE, S_WR_TVAL, S_WR_STATUS, S_REDIRECT
  } state_e;

  state_e          state_q, state_d;
  logic            is_trap_q, is_trap_d;
  logic            is_int_q, is_int_d;
  logic [4:0]      cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] pc_q, pc_d;
  // Supervisor flavour: delegated trap, or SRET for a return.
  logic            to_s_q, to_s_d;

  logic [XLEN-1:0] deleg_mask;
  logic            deleg;
  logic [XLEN-1:0] status_new;
  logic [1:0]      priv_new;
  logic [XLEN-1:0] tvec;
  logic [XLEN-1:0] redirect_target;

  assign dbgState   = state_q;
  assign deleg_mask = trapIsInterrupt ? mideleg : medeleg;
  assign deleg      = (privilege != 2'd3) && deleg_mask[trapCause];

  always_comb begin
    state_d   = state_q;
    is_trap_d = is_trap_q;
    is_int_d  = is_int_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    pc_d      = pc_q;
    to_s_d    = to_s_q;
    case (state_q)
      S_IDLE: begin
        if (trapValid) begin
          state_d   = S_DRAIN;
          is_trap_d = 1'b1;
          is_int_d  = trapIsInterrupt;
          cause_d   = trapCause;
          tval_d    = trapValue;
          pc_d      = trapPc;
          to_s_d    = deleg;
        end else if (retValid) begin
          state_d   = S_DRAIN;
          is_trap_d = 1'b0;
          is_int_d  = 1'b0;
          to_s_d    = (retPrivilege == 2'd1);
        end
      end
      S_DRAIN:     if (pipelineEmpty) state_d = is_trap_q ? S_WR_EPC : S_WR_STATUS;
      S_WR_EPC:    state_d = S_WR_CAUSE;
      S_WR_CAUSE:  state_d = S_WR_TVAL;
      S_WR_TVAL:   state_d = S_WR_STATUS;
      S_WR_STATUS: state_d = S_REDIRECT;
      S_REDIRECT:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    status_new = mstatus;
    priv_new   = 2'd3;
    if (is_trap_q) begin
      if (to_s_q) begin
        status_new[5] = mstatus[1];
        status_new[1] = 1'b0;
        status_new[8] = privilege[0];
        priv_new      = 2'd1;
      end else begin
        status_new[7]     = mstatus[3];
        status_new[3]     = 1'b0;
        status_new[12:11] = privilege;
        priv_new          = 2'd3;
      end
    end else if (to_s_q) begin
      status_new[1] = mstatus[5];
      status_new[5] = 1'b1;
      status_new[8] = 1'b0;
      priv_new      = {1'b0, mstatus[8]};
    end else begin
      status_new[3]     = mstatus[7];
      status_new[7]     = 1'b1;
      status_new[12:11] = 2'd0;
      priv_new          = mstatus[12:11];
    end
  end

  always_comb begin
    tvec            = to_s_q ? stvec : mtvec;
    redirect_target = tvec & ~{{(XLEN-2){1'b0}}, 2'b11};
    if (!is_trap_q) begin
      redirect_target = to_s_q ? sepc : mepc;
    end else if (VECTORED_ENABLE && tvec[1:0] == 2'b01 && is_int_q) begin
      redirect_target = redirect_target + {{(XLEN-7){1'b0}}, cause_q, 2'b00};
    end
  end

  always_comb begin
    reqReady        = 1'b0;
    flush           = 1'b1;
    privWriteEnable = 1'b0;
    privWriteValue  = 2'd0;
    csrWriteEnable  = pipeWriteEnable;
    csrWriteAddr    = pipeWriteAddr;
    csrWriteValue   = pipeWriteValue;
    redirectValid   = 1'b0;
    redirectPc      = '0;
    case (state_q)
      S_IDLE: begin
        reqReady = 1'b1;
        flush    = 1'b0;
      end
      S_DRAIN: ;
      S_WR_EPC: begin
        csrWriteEnable = 1'b1;
        csrWriteAddr   = to_s_q ? 12'h141 : 12'h341;
        csrWriteValue  = pc_q;
      end
      S_WR_CAUSE: begin
        csrWriteEnable = 1'b1;
        csrWriteAddr   = to_s_q ? 12'h142 : 12'h342;
        csrWriteValue  = {is_int_q, {(XLEN-6){1'b0}}, cause_q};
      end
      S_WR_TVAL: begin
        csrWriteEnable = 1'b1;
        csrWriteAddr   = to_s_q ? 12'h143 : 12'h343;
        csrWriteValue  = tval_q;
      end
      S_WR_STATUS: begin
        csrWriteEnable  = 1'b1;
        csrWriteAddr    = 12'h300;
        csrWriteValue   = status_new;
        privWriteEnable = 1'b1;
        privWriteValue  = priv_new;
      end
      default: begin
        csrWriteEnable = 1'b0;
        csrWriteAddr   = 12'h000;
        csrWriteValue  = '0;
        redirectValid  = 1'b1;
        redirectPc     = redirect_target;
      end
    endcase
    // Reset abandons any in-flight sequence; only the pipeline passthrough survives.
    if (rst) begin
      reqReady        = 1'b0;
      flush           = 1'b0;
      privWriteEnable = 1'b0;
      privWriteValue  = 2'd0;
      csrWriteEnable  = pipeWriteEnable;
      csrWriteAddr    = pipeWriteAddr;
      csrWriteValue   = pipeWriteValue;
      redirectValid   = 1'b0;
      redirectPc      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_trap_q <= 1'b0;
      is_int_q  <= 1'b0;
      cause_q   <= 5'd0;
      tval_q    <= '0;
      pc_q      <= '0;
      to_s_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_trap_q <= is_trap_d;
      is_int_q  <= is_int_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      pc_q      <= pc_d;
      to_s_q    <= to_s_d;
    end
  end

endmodule
